// File: rtl/arith_pckg.sv
// Shared fixed-point arithmetic definitions for the systolic-array datapath.
// Provides default operand/fraction widths, saturation limits, an operand
// bundle type and the rescale-and-saturate helper used after the multiply.
package arith_pckg;

  localparam int unsigned C_OP_WDT   = 16;
  localparam int unsigned C_FRAC_WDT = 8;

  localparam logic [C_OP_WDT-1:0] C_OP_MAX = {1'b0, {(C_OP_WDT-1){1'b1}}};
  localparam logic [C_OP_WDT-1:0] C_OP_MIN = {1'b1, {(C_OP_WDT-1){1'b0}}};

  typedef struct packed {
    logic [C_OP_WDT-1:0] data;
    logic                val;
  } op_t;

  // Arithmetic right shift by frac (floor, no rounding), then clamp to the
  // signed range of a wdt-bit result. Valid for wdt <= 31 so the full
  // product fits in 64 bits; the caller keeps the low wdt bits.
  function automatic logic signed [63:0] rescale_sat(input logic signed [63:0] p,
                                                     input int unsigned       frac,
                                                     input int unsigned       wdt);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = p >>> frac;
    max_v = (64'sd1 <<< (wdt - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (wdt - 1));
    if (r > max_v) begin
      return max_v;
    end else if (r < min_v) begin
      return min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/del_chain.sv
// Generic clock-enabled shift-register delay line.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (clears all stages)
//   clk_en       - global enable; every stage holds when low
//   in_word      - word entering the chain
//   in_word_del  - word delayed by DEL_CYC_LEN enabled cycles
// DEL_CYC_LEN = 0 is a plain wire with no registers.
module del_chain #(
  parameter int unsigned IN_WORD_WDT = 8,
  parameter int unsigned DEL_CYC_LEN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic [IN_WORD_WDT-1:0] in_word,
  output logic [IN_WORD_WDT-1:0] in_word_del
);

  if (DEL_CYC_LEN == 0) begin : g_bypass
    assign in_word_del = in_word;
  end else begin : g_regs
    logic [IN_WORD_WDT-1:0] stage_q [DEL_CYC_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEL_CYC_LEN); i++) begin
          stage_q[i] <= '0;
        end
      end else if (clk_en) begin
        stage_q[0] <= in_word;
        for (int i = 1; i < int'(DEL_CYC_LEN); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign in_word_del = stage_q[DEL_CYC_LEN-1];
  end

endmodule

// File: rtl/mult_del_pipe.sv
// Pipelined signed fixed-point multiplier cell for the systolic array.
// Operands are gated by their valid flags, delayed, registered into the
// multiplier, multiplied, rescaled, saturated and registered out.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clk_en              - global enable (only flow control, no backpressure)
//   op_a, op_a_val      - stationary operand and its valid
//   op_b, op_b_val      - moving operand and its valid
//   mult_res            - rescaled, saturated product (0 when not valid)
//   mult_res_val        - result valid
// Latency is DEL_CYC_LEN + MULT_IN_CYC_LEN + MULT_OUT_CYC_LEN enabled edges.
// MULT_IN_CYC_LEN and MULT_OUT_CYC_LEN must be >= 1; OP_WDT must be <= 31.
module mult_del_pipe
  import arith_pckg::*;
#(
  parameter int unsigned OP_WDT           = C_OP_WDT,
  parameter int unsigned FRAC_WDT         = C_FRAC_WDT,
  parameter int unsigned DEL_CYC_LEN      = 1,
  parameter int unsigned MULT_IN_CYC_LEN  = 1,
  parameter int unsigned MULT_OUT_CYC_LEN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [OP_WDT-1:0] op_a,
  input  logic              op_a_val,
  input  logic [OP_WDT-1:0] op_b,
  input  logic              op_b_val,
  output logic [OP_WDT-1:0] mult_res,
  output logic              mult_res_val
);

  localparam int unsigned BundleWdt = 2 * (OP_WDT + 1);

  logic [OP_WDT-1:0]    a_gated;
  logic [OP_WDT-1:0]    b_gated;
  logic [BundleWdt-1:0] opnd_in;
  logic [BundleWdt-1:0] opnd_del;
  logic [BundleWdt-1:0] opnd_mult;

  // Invalid operands enter the pipe as zero so nothing stale leaks through.
  assign a_gated = op_a_val ? op_a : '0;
  assign b_gated = op_b_val ? op_b : '0;
  assign opnd_in = {op_a_val, a_gated, op_b_val, b_gated};

  del_chain #(
    .IN_WORD_WDT(BundleWdt),
    .DEL_CYC_LEN(DEL_CYC_LEN)
  ) u_opnd_del (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .in_word    (opnd_in),
    .in_word_del(opnd_del)
  );

  del_chain #(
    .IN_WORD_WDT(BundleWdt),
    .DEL_CYC_LEN(MULT_IN_CYC_LEN)
  ) u_mult_in (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .in_word    (opnd_del),
    .in_word_del(opnd_mult)
  );

  logic              mult_a_val;
  logic              mult_b_val;
  logic [OP_WDT-1:0] mult_a;
  logic [OP_WDT-1:0] mult_b;

  assign mult_a_val = opnd_mult[BundleWdt-1];
  assign mult_a     = opnd_mult[BundleWdt-2 -: OP_WDT];
  assign mult_b_val = opnd_mult[OP_WDT];
  assign mult_b     = opnd_mult[OP_WDT-1:0];

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod;
  logic               res_val;
  logic [OP_WDT-1:0]  res_sat;
  logic [OP_WDT:0]    res_word;
  logic [OP_WDT:0]    res_word_del;

  // Combinational multiply and saturation between input and output stages.
  assign a_ext    = 64'($signed(mult_a));
  assign b_ext    = 64'($signed(mult_b));
  assign prod     = a_ext * b_ext;
  assign res_val  = mult_a_val & mult_b_val;
  assign res_sat  = OP_WDT'(rescale_sat(prod, FRAC_WDT, OP_WDT));
  assign res_word = res_val ? {1'b1, res_sat} : '0;

  del_chain #(
    .IN_WORD_WDT(OP_WDT + 1),
    .DEL_CYC_LEN(MULT_OUT_CYC_LEN)
  ) u_mult_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .in_word    (res_word),
    .in_word_del(res_word_del)
  );

  assign mult_res_val = res_word_del[OP_WDT];
  assign mult_res     = res_word_del[OP_WDT-1:0];

endmodule

// File: tb/tb_mult_del_pipe.sv
module tb_mult_del_pipe;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] op_a = '0;
  logic        op_a_val = 1'b0;
  logic [15:0] op_b = '0;
  logic        op_b_val = 1'b0;
  logic [15:0] mult_res;
  logic        mult_res_val;

  int checks = 0;
  int errors = 0;

  // Reference: queue of {val,res} results, L-1 deep after a pop.
  logic [16:0] pipe[$];
  logic [16:0] cur = '0;

  always #5 clk = ~clk;

  mult_del_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .op_a        (op_a),
    .op_a_val    (op_a_val),
    .op_b        (op_b),
    .op_b_val    (op_b_val),
    .mult_res    (mult_res),
    .mult_res_val(mult_res_val)
  );

  function automatic logic [16:0] model(input logic [15:0] a, input logic av,
                                        input logic [15:0] b, input logic bv);
    longint p;
    longint r;
    logic [15:0] lo;
    if (!(av && bv)) return 17'h0;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    lo = r[15:0];
    return {1'b1, lo};
  endfunction

  task automatic model_reset();
    pipe = {};
    for (int i = 0; i < L - 1; i++) pipe.push_back(17'h0);
    cur = '0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model; returns at posedge+1.
  task automatic tick(input logic [15:0] a, input logic av, input logic [15:0] b,
                      input logic bv, input logic en);
    op_a = a; op_a_val = av; op_b = b; op_b_val = bv; clk_en = en;
    @(posedge clk);
    if (en && rst_n) begin
      pipe.push_back(model(a, av, b, bv));
      cur = pipe.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mult_res_val, mult_res} !== 17'h0) begin
      errors++;
      $display("FAIL reset_hold: got val=%0b res=%h, want val=0 res=0000", mult_res_val, mult_res);
    end
    #5 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({mult_res_val, mult_res} !== 17'h0) begin
      errors++;
      $display("FAIL reset_release: got val=%0b res=%h, want 0/0000", mult_res_val, mult_res);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [7] = '{16'h0180, 16'hFF00, 16'h0001, 16'hFFFF, 16'h7F00, 16'h8000, 16'h8000};
    logic [15:0] vb [7] = '{16'h0200, 16'h0080, 16'h0001, 16'h0001, 16'h0200, 16'h0200, 16'h8000};
    logic [15:0] ve [7] = '{16'h0300, 16'hFF80, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF};
    for (int v = 0; v < 7; v++) begin
      for (int t = 0; t < L; t++) begin
        if (t == 0) tick(va[v], 1'b1, vb[v], 1'b1, 1'b1);
        else tick(16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (t < L - 1) begin
          if ({mult_res_val, mult_res} !== 17'h0) begin
            errors++;
            $display("FAIL directed_early v%0d t%0d: got %0b/%h, want 0/0000",
                     v, t, mult_res_val, mult_res);
          end
        end else if (mult_res_val !== 1'b1 || mult_res !== ve[v]) begin
          errors++;
          $display("FAIL directed_result %h*%h: got %0b/%h, want 1/%h",
                   va[v], vb[v], mult_res_val, mult_res, ve[v]);
        end
      end
    end
  endtask

  task automatic test_invalid();
    tick(16'h0100, 1'b1, 16'h0400, 1'b0, 1'b1);
    tick(16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick(16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if ({mult_res_val, mult_res} !== 17'h0) begin
      errors++;
      $display("FAIL invalid_b: got %0b/%h, want 0/0000", mult_res_val, mult_res);
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick(a, ($urandom_range(0, 7) != 0), b, ($urandom_range(0, 7) != 0), 1'b1);
      checks++;
      if ({mult_res_val, mult_res} !== cur) begin
        errors++;
        $display("FAIL stream[%0d]: got %0b/%h, want %0b/%h",
                 i, mult_res_val, mult_res, cur[16], cur[15:0]);
      end
    end
  endtask

  task automatic test_stall();
    logic en;
    for (int i = 0; i < 14; i++) begin
      en = !(i >= 3 && i < 8);
      tick(16'($urandom), 1'b1, 16'($urandom_range(0, 16'h03FF)), 1'b1, en);
      checks++;
      if ({mult_res_val, mult_res} !== cur) begin
        errors++;
        $display("FAIL stall[%0d] en=%0b: got %0b/%h, want %0b/%h",
                 i, en, mult_res_val, mult_res, cur[16], cur[15:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) tick(16'h0200, 1'b1, 16'h0100 + 16'(i), 1'b1, 1'b1);
    checks++;
    if (mult_res_val !== 1'b1 || {mult_res_val, mult_res} !== cur) begin
      errors++;
      $display("FAIL pre_reset: got %0b/%h, want %0b/%h",
               mult_res_val, mult_res, cur[16], cur[15:0]);
    end
    #2 rst_n = 1'b0;
    op_a_val = 1'b0; op_b_val = 1'b0;
    #1;
    checks++;
    if ({mult_res_val, mult_res} !== 17'h0) begin
      errors++;
      $display("FAIL async_reset: got %0b/%h, want 0/0000", mult_res_val, mult_res);
    end
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick(16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      checks++;
      if ({mult_res_val, mult_res} !== 17'h0) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %0b/%h, want 0/0000", i, mult_res_val, mult_res);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_invalid();
    test_random_stream();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_del_pipe.md
Name: mult_del_pipe

Overview:
- Pipelined fixed-point multiplier datapath for a systolic-array cell.
- Both operands (each with a valid flag) pass through a configurable delay chain (sub-module del_chain).
- A multiplier wrapper with input and output register stages then forms the signed product, rescales it and saturates it.
- The result feeds the adder tree. The only flow control is a global clock enable; there is no backpressure.

Parameters:
- OP_WDT, 16, operand/result width, signed two's complement.
- FRAC_WDT, 8, fractional bits of operands and result (Q(OP_WDT-FRAC_WDT).FRAC_WDT).
- DEL_CYC_LEN, 1, register stages in the operand delay chain; 0 = combinational pass-through.
- MULT_IN_CYC_LEN, 1, multiplier input register stages; legal values ≥1.
- MULT_OUT_CYC_LEN, 1, multiplier output register stages; legal values ≥1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clk_en  in  1  global clock enable.
- op_a  in  OP_WDT  operand A (stationary value).
- op_a_val  in  1  operand A valid.
- op_b  in  OP_WDT  operand B (moving value).
- op_b_val  in  1  operand B valid.
- mult_res  out  OP_WDT  rescaled, saturated product.
- mult_res_val  out  1  result valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, every register in every stage is cleared to 0 immediately (asynchronously). mult_res=0 and mult_res_val=0 during reset and until the first valid result emerges. Asserting reset mid-operation discards all in-flight data, with no partial results.
- Operand gating at input: an operand whose valid flag is 0 is replaced by 0 before entering the delay chain.
- Operand valid flags travel with their data.
- Latency: L = DEL_CYC_LEN + MULT_IN_CYC_LEN + MULT_OUT_CYC_LEN enabled cycles (default 3). Operands sampled on enabled edge n produce a result after enabled edge n+L-1, i.e. visible on outputs after L enabled edges.
- Throughput: one operand pair per enabled cycle.
- clk_en=0: every stage holds its contents and outputs are stable. Latency is therefore counted in enabled edges only.
- Valid: mult_res_val = delayed(op_a_val & op_b_val). When mult_res_val=0, mult_res is forced to 0.
- Arithmetic:
  - full product p = signed(a) * signed(b), 2*OP_WDT bits;
  - r = p >>> FRAC_WDT (arithmetic shift, truncation toward −inf, no rounding);
  - if r > 2^(OP_WDT-1)-1, output 0x7FFF (for OP_WDT=16); if r < −2^(OP_WDT-1), output 0x8000; else the low OP_WDT bits of r.
- Corner cases: (−max)×(−max) and 0x8000×0x8000 saturate positive. Zero or invalid operands give 0.
- Register placement: the product is computed combinationally between the last input stage and the first output stage. Saturation is applied before the first output register.
- del_chain DEL_CYC_LEN=0: output equals input combinationally, with no registers inferred.

Decomposition:
- Shared package arith_pckg: C_OP_WDT, C_FRAC_WDT, C_OP_MAX/C_OP_MIN saturation constants, a typed operand struct {data, val}, and a function implementing shift plus saturation.
- Sub-module del_chain (IN_WORD_WDT, DEL_CYC_LEN; ports clk, rst_n, clk_en, in_word, in_word_del): a generic shift-register delay.
  - Instantiated once for the 2×(OP_WDT+1)-bit operand bundle.
  - Reused internally for the multiplier input and output stages.
- Top-level wrapper (mult_del_pipe) holds the gating, the multiply and the saturation logic.

Test Plan:
- Basic multiply (defaults): op_a=0x0180 (1.5), op_b=0x0200 (2.0), both valid at cycle 0 -> mult_res=0x0300, mult_res_val=1 after exactly 3 enabled edges; both outputs 0 before that.
- Signs and truncation:
  - 0xFF00 (−1.0) × 0x0080 (0.5) -> 0xFF80;
  - 0x0001 × 0x0001 -> 0x0000;
  - 0xFFFF × 0x0001 -> 0xFFFF (floor).
- Saturation:
  - 0x7F00 × 0x0200 -> 0x7FFF;
  - 0x8000 × 0x0200 -> 0x8000;
  - 0x8000 × 0x8000 -> 0x7FFF.
- Validity:
  - op_a_val=1 with op_b_val=0 and op_b=0x0400 -> mult_res=0, mult_res_val=0 at latency;
  - streaming one new valid pair per cycle yields one correct result per cycle, in order.
- Stall: hold clk_en=0 for 5 cycles mid-stream -> outputs frozen; the remaining results appear in the same order once clk_en returns, each L enabled edges after its input.
- Async reset: assert rst_n=0 between edges with 2 results in flight -> mult_res and mult_res_val drop to 0 without a clock edge. After release, no stale results ever appear.
